// File: rtl/sr_io_pkg.sv
// Shared definitions for the serial shift-register input chain: frame geometry
// and symbolic names for the recovered input bits.
package sr_io_pkg;

    localparam int          SR_BITS       = 24;
    localparam logic [4:0]  SR_FRAME_LAST = 5'd24;

    // Input bit indices within in_raw
    localparam int IN_DISP_DATA = 0;
    localparam int IN_DISP_INT  = 1;
    localparam int IN_FP_BTN0   = 2;
    localparam int IN_FP_BTN1   = 3;
    localparam int IN_FP_BTN2   = 4;
    localparam int IN_FP_BTN3   = 5;
    localparam int IN_FP_SW0    = 6;
    localparam int IN_FP_SW1    = 7;

endpackage

// File: rtl/sr_in_debounce_if.sv
// Bundle between the shift-register controller / front-panel logic and the
// input debouncer: raw frame data in, debounced levels and event word out.
interface sr_in_debounce_if #(
    parameter int WIDTH = 24
);
    logic [4:0]       bitcount;
    logic [WIDTH-1:0] in_raw;
    logic [WIDTH-1:0] in_mask;
    logic             evt_ack;

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             frame_tick;
    logic             evt_valid;
    logic [WIDTH-1:0] evt_bits;
    logic             evt_ovf;

    modport master (
        output bitcount, in_raw, in_mask, evt_ack,
        input  stable, rise, fall, frame_tick, evt_valid, evt_bits, evt_ovf
    );

    modport slave (
        input  bitcount, in_raw, in_mask, evt_ack,
        output stable, rise, fall, frame_tick, evt_valid, evt_bits, evt_ovf
    );
endinterface

// File: rtl/sr_debounce_cell.sv
// One-bit frame-rate debouncer: a level change is accepted only after it has
// been seen on STABLE_FRAMES consecutive frame ticks.
module sr_debounce_cell #(
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = 4
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic tick,
    input  logic first,
    input  logic en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic chg
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_FRAMES - 1);

    logic             r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = d ^ r_q;
    // Acceptance is flagged combinationally so the event latch can update on
    // the same edge the pulse is registered.
    assign w_accept = tick & en & ~first & w_diff & (r_cnt == CNT_LAST);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_q    <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (tick) begin
                if (!en) begin
                    r_q   <= 1'b0;
                    r_cnt <= '0;
                end else if (first) begin
                    r_q   <= d;
                    r_cnt <= '0;
                end else if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_q    <= d;
                    r_cnt  <= '0;
                    r_rise <= d;
                    r_fall <= ~d;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign chg  = w_accept;

endmodule

// File: rtl/sr_in_debounce.sv
// Frame-synchronous debouncer and sticky event latch for the parallel inputs
// recovered from the shift-register chain; one update per frame.
module sr_in_debounce
    import sr_io_pkg::*;
#(
    parameter int WIDTH         = SR_BITS,
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = 4
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    sr_in_debounce_if.slave   bus
);
    logic             r_last_q;
    logic             r_last_q2;
    logic             r_first;
    logic [WIDTH-1:0] r_evt_bits;
    logic             r_evt_ovf;

    logic             w_tick;
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_evt_keep;
    logic [WIDTH-1:0] w_evt_nxt;
    logic             w_ovf_nxt;

    // Tick lands in the cycle after the last bit, when in23 is valid; a
    // bitcount parked on the last value yields only the one rising edge.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_last_q  <= 1'b0;
            r_last_q2 <= 1'b0;
        end else begin
            r_last_q  <= (bus.bitcount == SR_FRAME_LAST);
            r_last_q2 <= r_last_q;
        end
    end

    assign w_tick   = r_last_q & ~r_last_q2;
    assign w_sample = bus.in_raw & bus.in_mask;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N)      r_first <= 1'b1;
        else if (w_tick) r_first <= 1'b0;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_debounce_cell #(
            .STABLE_FRAMES (STABLE_FRAMES),
            .CNT_W         (CNT_W)
        ) u_cell (
            .CLK_IN (CLK_IN),
            .RST_N  (RST_N),
            .tick   (w_tick),
            .first  (r_first),
            .en     (bus.in_mask[g]),
            .d      (w_sample[g]),
            .q      (w_stable[g]),
            .rise   (w_rise[g]),
            .fall   (w_fall[g]),
            .chg    (w_chg[g])
        );
    end

    // A change arriving with the ack survives it; masked bits drop their
    // pending event on the tick.
    always_comb begin
        w_evt_keep = bus.evt_ack ? '0 : r_evt_bits;
        w_evt_nxt  = (w_evt_keep | w_chg) & (w_tick ? bus.in_mask : {WIDTH{1'b1}});
        w_ovf_nxt  = (bus.evt_ack ? 1'b0 : r_evt_ovf)
                   | (|(r_evt_bits & w_chg & ~{WIDTH{bus.evt_ack}}));
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_evt_bits <= '0;
            r_evt_ovf  <= 1'b0;
        end else begin
            r_evt_bits <= w_evt_nxt;
            r_evt_ovf  <= w_ovf_nxt;
        end
    end

    assign bus.stable     = w_stable;
    assign bus.rise       = w_rise;
    assign bus.fall       = w_fall;
    assign bus.frame_tick = w_tick;
    assign bus.evt_bits   = r_evt_bits;
    assign bus.evt_ovf    = r_evt_ovf;
    assign bus.evt_valid  = |r_evt_bits;

endmodule

// File: tb/tb_sr_in_debounce.sv
// Bench for sr_in_debounce: directed scenarios plus randomized frames checked
// against a per-bit streak model of the debounce and event rules.
module tb_sr_in_debounce;
    import sr_io_pkg::*;

    localparam int W  = 24;
    localparam int SF = 4;

    logic CLK_IN = 1'b0;
    logic RST_N  = 1'b0;

    sr_in_debounce_if #(.WIDTH(W)) bus();

    sr_in_debounce #(
        .WIDTH         (W),
        .STABLE_FRAMES (SF),
        .CNT_W         (4)
    ) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    always #5 CLK_IN = ~CLK_IN;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_stable, m_evt, m_rise, m_fall;
    logic         m_ovf, m_first;
    int           m_streak [W];
    int           t_ticks;

    task automatic model_reset();
        m_stable = '0; m_evt = '0; m_rise = '0; m_fall = '0;
        m_ovf = 1'b0; m_first = 1'b1;
        for (int i = 0; i < W; i++) m_streak[i] = 0;
    endtask

    // Count consecutive frames a bit disagrees with its accepted level;
    // the SF-th such frame flips it.
    task automatic model_tick(input logic [W-1:0] raw, input logic [W-1:0] mask, input logic ack);
        logic [W-1:0] s, chg;
        s = raw & mask;
        m_rise = '0; m_fall = '0;
        if (m_first) begin
            m_stable = s;
            m_first  = 1'b0;
            for (int i = 0; i < W; i++) m_streak[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (!mask[i]) begin
                    m_stable[i] = 1'b0;
                    m_streak[i] = 0;
                end else if (s[i] != m_stable[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == SF) begin
                        m_stable[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
        chg   = m_rise | m_fall;
        m_ovf = (ack ? 1'b0 : m_ovf) | (!ack && ((m_evt & chg) != '0));
        m_evt = ((ack ? '0 : m_evt) | chg) & mask;
    endtask

    // Drives one full frame; returns at the negedge after the updating edge.
    task automatic run_frame(input logic [W-1:0] raw, input logic [W-1:0] mask, input logic ack);
        t_ticks = 0;
        bus.in_raw  = raw;
        bus.in_mask = mask;
        for (int b = 0; b <= 24; b++) begin
            bus.bitcount = 5'(b);
            @(negedge CLK_IN);
            t_ticks += int'(bus.frame_tick);
        end
        bus.bitcount = 5'd0;
        bus.evt_ack  = ack;
        @(negedge CLK_IN);
        bus.evt_ack  = 1'b0;
        model_tick(raw, mask, ack);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.bitcount = 5'd0; bus.in_raw = '0; bus.in_mask = '1; bus.evt_ack = 1'b0;
        repeat (3) @(negedge CLK_IN);
        model_reset();
        checks++; if (bus.stable !== '0) begin errors++; $display("FAIL reset_stable: got %h want 0", bus.stable); end
        checks++; if ((bus.rise | bus.fall) !== '0) begin errors++; $display("FAIL reset_pulses: got %h/%h want 0", bus.rise, bus.fall); end
        checks++; if ({bus.frame_tick, bus.evt_valid, bus.evt_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.frame_tick, bus.evt_valid, bus.evt_ovf}); end
        checks++; if (bus.evt_bits !== '0) begin errors++; $display("FAIL reset_evt: got %h want 0", bus.evt_bits); end
        RST_N = 1'b1;
        @(negedge CLK_IN);
    endtask

    task automatic test_first_frame();
        run_frame(24'h00A5F0, '1, 1'b0);
        checks++; if (t_ticks != 1) begin errors++; $display("FAIL first_ticks: got %0d want 1", t_ticks); end
        checks++; if (bus.stable !== 24'h00A5F0) begin errors++; $display("FAIL first_stable: got %h want 00a5f0", bus.stable); end
        checks++; if ((bus.rise | bus.fall) !== '0) begin errors++; $display("FAIL first_pulses: got %h/%h want 0", bus.rise, bus.fall); end
        checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL first_evt_valid: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_rise();
        for (int k = 1; k <= SF; k++) begin
            run_frame(24'h00A5F8, '1, 1'b0);
            checks++; if (bus.stable !== m_stable || bus.rise !== m_rise) begin errors++; $display("FAIL rise_frame%0d: got %h/%h want %h/%h", k, bus.stable, bus.rise, m_stable, m_rise); end
        end
        checks++; if (bus.rise !== 24'h000008) begin errors++; $display("FAIL rise_pulse: got %h want 000008", bus.rise); end
        checks++; if (bus.evt_bits !== 24'h000008 || bus.evt_valid !== 1'b1) begin errors++; $display("FAIL rise_evt: got %h/%b want 000008/1", bus.evt_bits, bus.evt_valid); end
        @(negedge CLK_IN);
        checks++; if (bus.rise !== '0) begin errors++; $display("FAIL rise_one_cycle: got %h want 0", bus.rise); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] cur;
        cur = 24'h00A5F8;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < SF - 1; k++) run_frame(cur ^ 24'h20, '1, 1'b0);
            checks++; if (bus.stable !== m_stable || bus.stable !== cur) begin errors++; $display("FAIL glitch_hold%0d: got %h want %h", rep, bus.stable, cur); end
            run_frame(cur, '1, 1'b0);
            checks++; if ((bus.rise | bus.fall) !== '0 || bus.stable !== cur) begin errors++; $display("FAIL glitch_pulse%0d: got %h/%h want 0 stable %h", rep, bus.rise | bus.fall, bus.stable, cur); end
        end
    endtask

    task automatic test_ovf();
        for (int k = 0; k < SF; k++) run_frame(24'h00A5F0, '1, 1'b0);
        checks++; if (bus.fall !== 24'h000008) begin errors++; $display("FAIL ovf_fall: got %h want 000008", bus.fall); end
        checks++; if (bus.evt_bits !== 24'h000008 || bus.evt_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %h/%b want 000008/1", bus.evt_bits, bus.evt_ovf); end
        bus.evt_ack = 1'b1;
        @(negedge CLK_IN);
        bus.evt_ack = 1'b0;
        m_evt = '0; m_ovf = 1'b0;
        checks++; if (bus.evt_bits !== '0 || bus.evt_ovf !== 1'b0 || bus.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_ack: got %h/%b/%b want 0/0/0", bus.evt_bits, bus.evt_ovf, bus.evt_valid); end
        for (int k = 1; k <= SF; k++) run_frame(24'h00A570, '1, (k == SF));
        checks++; if (bus.evt_bits !== 24'h000080 || bus.evt_bits !== m_evt) begin errors++; $display("FAIL ack_same_cycle: got %h want 000080", bus.evt_bits); end
        checks++; if (bus.evt_ovf !== 1'b0 || bus.fall !== 24'h000080) begin errors++; $display("FAIL ack_same_cycle_ovf: got %b/%h want 0/000080", bus.evt_ovf, bus.fall); end
    endtask

    task automatic test_hold_and_reset();
        int ticks;
        ticks = 0;
        bus.bitcount = 5'd24;
        repeat (10) begin @(negedge CLK_IN); ticks += int'(bus.frame_tick); end
        model_tick(bus.in_raw, bus.in_mask, 1'b0);
        bus.bitcount = 5'd0;
        repeat (2) begin @(negedge CLK_IN); ticks += int'(bus.frame_tick); end
        checks++; if (ticks != 1) begin errors++; $display("FAIL hold_ticks: got %0d want 1", ticks); end
        checks++; if (bus.stable !== m_stable || bus.evt_bits !== m_evt) begin errors++; $display("FAIL hold_state: got %h/%h want %h/%h", bus.stable, bus.evt_bits, m_stable, m_evt); end
        // Reset partway through a frame, off the clock edge
        bus.in_raw = 24'h5A0F04;
        for (int b = 0; b <= 10; b++) begin bus.bitcount = 5'(b); @(negedge CLK_IN); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (bus.stable !== '0 || bus.evt_bits !== '0 || (bus.rise | bus.fall) !== '0) begin errors++; $display("FAIL async_reset_vec: got %h/%h/%h want 0", bus.stable, bus.evt_bits, bus.rise | bus.fall); end
        checks++; if ({bus.frame_tick, bus.evt_valid, bus.evt_ovf} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b want 000", {bus.frame_tick, bus.evt_valid, bus.evt_ovf}); end
        @(negedge CLK_IN);
        RST_N = 1'b1;
        model_reset();
        run_frame(24'h5A0F04, '1, 1'b0);
        checks++; if (bus.stable !== 24'h5A0F04 || bus.rise !== '0 || bus.evt_valid !== 1'b0) begin errors++; $display("FAIL post_reset_frame: got %h/%h/%b want 5a0f04/0/0", bus.stable, bus.rise, bus.evt_valid); end
    endtask

    task automatic test_mask();
        logic [W-1:0] cur;
        cur = 24'h5A0F04;
        for (int k = 0; k < SF; k++) run_frame(cur & ~24'h4, '1, 1'b0);
        for (int k = 0; k < SF; k++) run_frame(cur, '1, 1'b0);
        checks++; if (bus.evt_bits !== 24'h4 || bus.stable[2] !== 1'b1 || bus.evt_ovf !== m_ovf) begin errors++; $display("FAIL mask_setup: got %h/%b/%b want 000004/1/%b", bus.evt_bits, bus.stable[2], bus.evt_ovf, m_ovf); end
        run_frame(cur, ~24'h4, 1'b0);
        checks++; if (bus.stable[2] !== 1'b0 || bus.stable !== m_stable) begin errors++; $display("FAIL mask_stable: got %h want %h", bus.stable, m_stable); end
        checks++; if (bus.fall !== '0 || bus.evt_bits[2] !== 1'b0) begin errors++; $display("FAIL mask_quiet: got fall %h evt %h want 0", bus.fall, bus.evt_bits); end
    endtask

    task automatic test_random();
        logic [W-1:0] base, raw, mask;
        logic         ack;
        base = m_stable;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(2) == 0) base[$urandom_range(W-1)] ^= 1'b1;
            raw  = base;
            if ($urandom_range(4) == 0) raw[$urandom_range(W-1)] ^= 1'b1;
            mask = '1;
            if ($urandom_range(5) == 0) mask[$urandom_range(W-1)] = 1'b0;
            ack  = ($urandom_range(3) == 0);
            run_frame(raw, mask, ack);
            checks++; if (bus.stable !== m_stable) begin errors++; $display("FAIL rnd%0d_stable: got %h want %h", f, bus.stable, m_stable); end
            checks++; if (bus.rise !== m_rise || bus.fall !== m_fall) begin errors++; $display("FAIL rnd%0d_pulses: got %h/%h want %h/%h", f, bus.rise, bus.fall, m_rise, m_fall); end
            checks++; if (bus.evt_bits !== m_evt || bus.evt_valid !== (m_evt != '0)) begin errors++; $display("FAIL rnd%0d_evt: got %h/%b want %h", f, bus.evt_bits, bus.evt_valid, m_evt); end
            checks++; if (bus.evt_ovf !== m_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %b want %b", f, bus.evt_ovf, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_rise();
        test_glitch();
        test_ovf();
        test_hold_and_reset();
        test_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
